// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the instruction sequencer: state encoding,
// register/bus indices, opcode values and IR field positions.
package ctrl_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_e;

    // Register / bus source indices (R0..R15 are 0..15)
    localparam logic [4:0] IDX_HI     = 5'd16;
    localparam logic [4:0] IDX_LO     = 5'd17;
    localparam logic [4:0] IDX_ZHI    = 5'd18;
    localparam logic [4:0] IDX_ZLO    = 5'd19;
    localparam logic [4:0] IDX_PC     = 5'd20;
    localparam logic [4:0] IDX_MDR    = 5'd21;
    localparam logic [4:0] IDX_INPORT = 5'd22;
    localparam logic [4:0] IDX_IR     = 5'd23;
    localparam logic [4:0] IDX_Z      = 5'd24;
    localparam logic [4:0] IDX_MAR    = 5'd25;
    localparam logic [4:0] IDX_Y      = 5'd27;

    localparam logic [4:0] OP_ALU_FIRST = 5'b00011;
    localparam logic [4:0] OP_ALU_LAST  = 5'b01100;
    localparam logic [4:0] OP_MUL       = 5'b01111;
    localparam logic [4:0] OP_DIV       = 5'b10000;
    localparam logic [4:0] OP_NOP       = 5'b11010;
    localparam logic [4:0] OP_HALT      = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    function automatic logic is_alu(input logic [4:0] op);
        return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Sequencer <-> datapath control bundle. master = sequencer, slave = datapath.
interface ctrl_seq_if;
    logic        run;
    logic        mem_rdy;
    logic [31:0] ir;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic        MR_Read;
    logic        pc_inc;
    logic [4:0]  opcode;
    logic        busy;
    logic        err;

    modport master (
        input  run, mem_rdy, ir,
        output enable, busSelect, MR_Read, pc_inc, opcode, busy, err
    );

    modport slave (
        output run, mem_rdy, ir,
        input  enable, busSelect, MR_Read, pc_inc, opcode, busy, err
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational Moore decode of (state, ir) into datapath control strobes.
module ctrl_decode
    import ctrl_seq_pkg::*;
(
    input  state_e      state_i,
    input  logic [31:0] ir_i,
    output logic [31:0] enable_o,
    output logic [31:0] busSelect_o,
    output logic        MR_Read_o,
    output logic        pc_inc_o,
    output logic [4:0]  opcode_o
);
    logic [4:0] op, sel;
    logic [3:0] ra, rb, rc;
    logic       unused_ir_lo;

    assign op = ir_i[OPC_MSB:OPC_LSB];
    assign ra = ir_i[RA_MSB:RA_LSB];
    assign rb = ir_i[RB_MSB:RB_LSB];
    assign rc = ir_i[RC_MSB:RC_LSB];
    assign unused_ir_lo = ^ir_i[RC_LSB-1:0];

    assign busSelect_o = {27'd0, sel};

    always_comb begin
        enable_o  = '0;
        sel       = '0;
        MR_Read_o = 1'b0;
        pc_inc_o  = 1'b0;
        opcode_o  = '0;
        case (state_i)
            S_T0: begin
                sel               = IDX_PC;
                enable_o[IDX_MAR] = 1'b1;
                enable_o[IDX_PC]  = 1'b1;
                pc_inc_o          = 1'b1;
            end
            S_T1: begin
                MR_Read_o         = 1'b1;
                enable_o[IDX_MDR] = 1'b1;
            end
            S_T2: begin
                sel              = IDX_MDR;
                enable_o[IDX_IR] = 1'b1;
            end
            // T3 is also the decode cycle; non-execute opcodes drive nothing here
            S_T3: begin
                if (is_alu(op) || is_muldiv(op)) begin
                    sel             = {1'b0, rb};
                    enable_o[IDX_Y] = 1'b1;
                end
            end
            S_T4: begin
                sel             = {1'b0, rc};
                opcode_o        = op;
                enable_o[IDX_Z] = 1'b1;
            end
            S_T5: begin
                sel = IDX_ZLO;
                if (is_muldiv(op)) enable_o[IDX_LO]        = 1'b1;
                else               enable_o[{1'b0, ra}]    = 1'b1;
            end
            S_T6: begin
                sel              = IDX_ZHI;
                enable_o[IDX_HI] = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/ctrl_seq.sv
// Fetch/decode/execute sequencer: state register, next-state logic and the
// sticky illegal-opcode flag; strobe decode lives in ctrl_decode.
module ctrl_seq
    import ctrl_seq_pkg::*;
(
    input logic        clk,
    input logic        clr,
    ctrl_seq_if.master bus
);
    state_e     state_q, state_d;
    logic       err_q, err_d;
    logic [4:0] op;

    assign op = bus.ir[OPC_MSB:OPC_LSB];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // IR loads at the end of T2, so opcode dispatch happens during T3
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (bus.run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (bus.mem_rdy) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_alu(op) || is_muldiv(op)) state_d = S_T4;
                else if (op == OP_NOP)           state_d = bus.run ? S_T0 : S_IDLE;
                else if (op == OP_HALT)          state_d = S_HALT;
                else begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = is_muldiv(op) ? S_T6 : (bus.run ? S_T0 : S_IDLE);
            S_T6:   state_d = bus.run ? S_T0 : S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.err  = err_q;

    ctrl_decode u_dec (
        .state_i    (state_q),
        .ir_i       (bus.ir),
        .enable_o   (bus.enable),
        .busSelect_o(bus.busSelect),
        .MR_Read_o  (bus.MR_Read),
        .pc_inc_o   (bus.pc_inc),
        .opcode_o   (bus.opcode)
    );
endmodule

// File: tb/tb_ctrl_seq.sv
// Directed-vector bench for ctrl_seq: fetch/execute sequences, T1 wait,
// MUL, illegal opcode, mid-instruction clr and run drop.
module tb_ctrl_seq;
    logic clk = 1'b0;
    logic clr;
    int   n_chk = 0;
    int   n_fail = 0;

    ctrl_seq_if sif ();
    ctrl_seq dut (.clk(clk), .clr(clr), .bus(sif));

    always #5 clk = ~clk;

    localparam logic [31:0] IR_SHL  = 32'h489A8000;
    localparam logic [31:0] IR_MUL  = {5'b01111, 4'd2, 4'd3, 4'd5, 15'd0};
    localparam logic [31:0] IR_ILL  = {5'b11100, 27'd0};
    localparam logic [31:0] EN_T0   = (32'd1 << 25) | (32'd1 << 20);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_st(input string tag, input logic [31:0] bsel, input logic [31:0] en,
                          input logic mr, input logic inc, input logic [4:0] opc,
                          input logic bsy, input logic e);
        chk({tag, ".bus"},    sif.busSelect, bsel);
        chk({tag, ".en"},     sif.enable,    en);
        chk({tag, ".mr"},     {31'd0, sif.MR_Read}, {31'd0, mr});
        chk({tag, ".inc"},    {31'd0, sif.pc_inc},  {31'd0, inc});
        chk({tag, ".opc"},    {27'd0, sif.opcode},  {27'd0, opc});
        chk({tag, ".busy"},   {31'd0, sif.busy},    {31'd0, bsy});
        chk({tag, ".err"},    {31'd0, sif.err},     {31'd0, e});
    endtask

    task automatic exp_fetch(input string tag);
        exp_st({tag, ".T0"}, 32'd20, EN_T0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0); tick();
        exp_st({tag, ".T1"}, 32'd0, 32'd1 << 21, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0); tick();
        exp_st({tag, ".T2"}, 32'd21, 32'd1 << 23, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clr = 1'b1; sif.run = 1'b0; sif.mem_rdy = 1'b0; sif.ir = '0;
        #12;
        exp_st("reset", 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        clr = 1'b0;
        tick();
        exp_st("idle", 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // SHL R1,R3,R5
        sif.run = 1'b1; sif.mem_rdy = 1'b1; sif.ir = IR_SHL;
        tick();
        exp_fetch("shl");
        exp_st("shl.T3", 32'd3, 32'd1 << 27, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); tick();
        exp_st("shl.T4", 32'd5, 32'd1 << 24, 1'b0, 1'b0, 5'b01001, 1'b1, 1'b0); tick();
        exp_st("shl.T5", 32'd19, 32'd1 << 1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); tick();

        // T1 wait for 3 extra cycles, then MUL
        exp_st("wait.T0", 32'd20, EN_T0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
        sif.mem_rdy = 1'b0;
        tick();
        exp_st("wait.T1a", 32'd0, 32'd1 << 21, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_st($sformatf("wait.T1h%0d", i), 32'd0, 32'd1 << 21, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        end
        sif.mem_rdy = 1'b1;
        tick();
        exp_st("wait.T2", 32'd21, 32'd1 << 23, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        sif.ir = IR_MUL;
        tick();
        exp_st("mul.T3", 32'd3, 32'd1 << 27, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); tick();
        exp_st("mul.T4", 32'd5, 32'd1 << 24, 1'b0, 1'b0, 5'b01111, 1'b1, 1'b0); tick();
        exp_st("mul.T5", 32'd19, 32'd1 << 17, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); tick();
        exp_st("mul.T6", 32'd18, 32'd1 << 16, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); tick();

        // run dropped during T3: instruction completes, then IDLE
        sif.ir = IR_SHL;
        exp_fetch("drop");
        sif.run = 1'b0;
        exp_st("drop.T3", 32'd3, 32'd1 << 27, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); tick();
        exp_st("drop.T4", 32'd5, 32'd1 << 24, 1'b0, 1'b0, 5'b01001, 1'b1, 1'b0); tick();
        exp_st("drop.T5", 32'd19, 32'd1 << 1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); tick();
        exp_st("drop.idle", 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
        exp_st("drop.idle2", 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // clr mid-T4
        sif.run = 1'b1;
        tick();
        exp_fetch("abort");
        tick();
        exp_st("abort.T4", 32'd5, 32'd1 << 24, 1'b0, 1'b0, 5'b01001, 1'b1, 1'b0);
        #2 clr = 1'b1;
        #1 exp_st("abort.clr", 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        exp_st("abort.edge", 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        clr = 1'b0;
        tick();

        // illegal opcode: err, HALT, stays until clr
        sif.ir = IR_ILL;
        exp_fetch("ill");
        tick(); tick(); tick();
        exp_st("ill.halt", 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick(); tick(); tick();
        exp_st("ill.stay", 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        #2 clr = 1'b1;
        #1 exp_st("ill.clr", 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        clr = 1'b0;
        sif.ir = IR_SHL;
        tick();
        exp_st("restart.T0", 32'd20, EN_T0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port clr, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port run, input, 1 bit: when high, fetch and execute instructions continuously.
REQ-004 SHALL have port mem_rdy, input, 1 bit: memory read data is valid on MDataIn.
REQ-005 SHALL have port ir, input, 32 bits: current datapath IR contents. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
REQ-006 SHALL have port enable, output, 32 bits: one-hot register load enables, indexed per the package.
REQ-007 SHALL have port busSelect, output, 32 bits: bus source index in [4:0]; bits [31:5] are always zero.
REQ-008 SHALL have port MR_Read, output, 1 bit: MDR loads from MDataIn.
REQ-009 SHALL have port pc_inc, output, 1 bit: PC loads PC+1 instead of the bus.
REQ-010 SHALL have port opcode, output, 5 bits: ALU operation select.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE and HALT.
REQ-012 SHALL have port err, output, 1 bit: sticky illegal-opcode flag.

Function
REQ-013 SHALL implement the states IDLE, T0, T1, T2, T3, T4, T5, T6 and HALT.
REQ-014 IDLE SHALL move to T0 when run=1; otherwise it stays in IDLE.
REQ-015 T0 SHALL drive busSelect=PC, enable MAR and PC, and pc_inc=1.
REQ-016 T1 SHALL drive MR_Read=1 and enable MDR, and SHALL hold in T1 until mem_rdy=1, then go to T2.
REQ-017 T2 SHALL drive busSelect=MDR and enable IR.
REQ-018 At the end of T2, decode SHALL use the value on the ir port in the next cycle:
- three-register ALU op (00011..01100): go to T3.
- MUL (01111) or DIV (10000): go to T3.
- NOP (11010): go to T0 if run=1, else IDLE.
- HALT (11011): go to HALT.
- any other opcode: set err and go to HALT.
REQ-019 T3 SHALL drive busSelect=R[Rb] and enable Y.
REQ-020 T4 SHALL drive busSelect=R[Rc], opcode=ir[31:27], and enable Z.
REQ-021 T5 SHALL drive busSelect=ZLO:
- for an ALU op it SHALL enable R[Ra];
- for MUL/DIV it SHALL enable LO and go to T6.
REQ-022 T6 SHALL drive busSelect=ZHI and enable HI.
REQ-023 Last execute state (T5 for ALU ops, T6 for MUL/DIV): go to T0 if run=1, else IDLE.
REQ-024 HALT SHALL be exited only by clr.
REQ-025 Dropping run mid-instruction SHALL NOT abort the instruction; the instruction completes and the sequencer then enters IDLE.
REQ-026 At most one enable bit SHALL be set in any state, except in T0 where both MAR and PC are set.
REQ-027 All outputs SHALL be Moore decodes of the state register and ir; no output depends combinationally on run or mem_rdy.
REQ-028 In states that do not drive a signal, that signal SHALL be zero.
REQ-029 A T1 wait of any length SHALL hold the T1 outputs stable.

Reset
REQ-030 clr=1 SHALL immediately force the state to IDLE, with enable=0, busSelect=0, MR_Read=0, pc_inc=0, opcode=0, busy=0 and err=0.
REQ-031 Asserting clr in any state, including mid-wait in T1, SHALL abort the instruction with no further enables.
REQ-032 After clr is released, the first transition SHALL occur on the next rising clk edge with run=1.

Structure
REQ-033 A shared package SHALL hold:
- the state enum;
- register/bus indices: R0..R15=0..15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, IR=23, Z=24, MAR=25, Y=27;
- opcode constants;
- the IR field bit positions.
REQ-034 A single sub-module, ctrl_decode, SHALL be combinational and map (state, ir) to enable, busSelect, MR_Read, pc_inc and opcode.

Verification
REQ-035 Scenario: clr pulse, then run=1, mem_rdy=1, ir=32'h489A8000 (SHL R1,R3,R5).
- Required sequence, one cycle each: T0 bus=20, en{25,20}; T1 en21 with MR_Read; T2 bus=21, en23; T3 bus=3, en27; T4 bus=5, opcode=01001, en24; T5 bus=19, en1; then T0.
REQ-036 Scenario: mem_rdy held low for 3 cycles in T1. Required: T1 outputs are held for 4 cycles, then T2.
REQ-037 Scenario: ir opcode 01111 (MUL, Rb=R3, Rc=R5). Required: T5 bus=19 with en17, then T6 bus=18 with en16.
REQ-038 Scenario: ir opcode 11100. Required: err=1, HALT, busy=0; it stays there with run=1 until clr, which clears err.
REQ-039 Scenario: clr asserted mid-T4. Required: outputs zero and IDLE within the same cycle, with no Z load on the following edge.
REQ-040 Scenario: run dropped during T3. Required: T4 and T5 complete, then IDLE with busy=0.
